// File: rtl/deserializer_pkg.sv
// deserializer shared types and defaults.
// Word width, idle timeout and length-field sizing.
package deserializer_pkg;

    typedef enum logic {
        IDLE,
        RECV
    } deser_state_t;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_TIMEOUT = 4;

    function automatic int len_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/deser_out_reg.sv
// Valid/ready holding register for assembled words.
// Drops a new word when the held one is stalled.
module deser_out_reg
    import deserializer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LW     = len_w(DEF_DATA_W)
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LW-1:0]     len_i,
    input  logic              rdy_i,
    output logic              val_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LW-1:0]     len_o,
    output logic              overflow_o
);

    // load on free/draining slot, flag overflow on stall, clear on accept
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            val_o      <= 1'b0;
            data_o     <= '0;
            len_o      <= '0;
            overflow_o <= 1'b0;
        end else if (load_i) begin
            if (!val_o || rdy_i) begin
                val_o  <= 1'b1;
                data_o <= data_i;
                len_o  <= len_i;
            end else begin
                overflow_o <= 1'b1;
            end
        end else if (val_o && rdy_i) begin
            val_o <= 1'b0;
        end
    end

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel receiver, MSB first.
// Short words are flushed left-aligned after an idle timeout.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                        clk_i,
    input  logic                        arstn_i,
    input  logic                        ser_data_i,
    input  logic                        ser_data_val_i,
    output logic [DATA_W-1:0]           deser_data_o,
    output logic [len_w(DATA_W)-1:0]    deser_len_o,
    output logic                        deser_data_val_o,
    input  logic                        deser_data_rdy_i,
    output logic                        busy_o,
    output logic                        overflow_o
);

    localparam int LW = len_w(DATA_W);
    // idle counter only needs to hold 0..TIMEOUT-1
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    deser_state_t      state_q;
    deser_state_t      state_d;
    logic [DATA_W-1:0] shift_q;
    logic [LW-1:0]     cnt_q;
    logic [IW-1:0]     idle_q;
    logic              complete;
    logic              timeout;
    logic              load;
    logic [DATA_W-1:0] load_data;
    logic [LW-1:0]     load_len;

    assign complete = ser_data_val_i && (cnt_q == LW'(DATA_W - 1));
    assign timeout  = (state_q == RECV) && !ser_data_val_i &&
                      (idle_q == IW'(TIMEOUT - 1));
    assign busy_o   = (state_q == RECV);

    // state register
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: enter on first bit, leave on completion or timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (ser_data_val_i) state_d = RECV;
            RECV: if (complete || timeout) state_d = IDLE;
        endcase
    end

    // word handed to the output register on completion or flush
    always_comb begin
        load      = 1'b0;
        load_data = '0;
        load_len  = '0;
        if (complete) begin
            load      = 1'b1;
            load_data = {shift_q[DATA_W-2:0], ser_data_i};
            load_len  = LW'(DATA_W);
        end else if (timeout) begin
            load      = 1'b1;
            load_data = shift_q << (LW'(DATA_W) - cnt_q);
            load_len  = cnt_q;
        end
    end

    // shift register, bit counter and idle counter
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
            idle_q  <= '0;
        end else if (ser_data_val_i) begin
            shift_q <= {shift_q[DATA_W-2:0], ser_data_i};
            cnt_q   <= complete ? '0 : cnt_q + 1'b1;
            idle_q  <= '0;
        end else if (timeout) begin
            cnt_q  <= '0;
            idle_q <= '0;
        end else if (state_q == RECV) begin
            idle_q <= idle_q + 1'b1;
        end
    end

    deser_out_reg #(
        .DATA_W(DATA_W),
        .LW    (LW)
    ) u_out (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .load_i    (load),
        .data_i    (load_data),
        .len_i     (load_len),
        .rdy_i     (deser_data_rdy_i),
        .val_o     (deser_data_val_o),
        .data_o    (deser_data_o),
        .len_o     (deser_len_o),
        .overflow_o(overflow_o)
    );

endmodule
